uart_rx: RTL and testbench

Serial-to-stream UART receiver, the downstream peer of the transmitter: it decodes 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous `rx` line and delivers each byte on an AXI-stream-style output. It uses the same `cycles_per_bit` timing as the transmitter, so one parameter value pairs both ends of a link. It sits between the board/bench serial pin and the byte-consuming logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 34 +++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame geometry constants used by the receiver.
package uart_pkg;

   // Number of data bits carried by one 8N1 frame.
   localparam int UART_DATA_BITS = 8;

   // Receiver frame-decoding states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_RECOVER = 3'd4
   } rx_state_t;

   // Offset from the start edge to the middle of the start bit.
   function automatic int half_bit_cycles(input int cycles_per_bit);
      return cycles_per_bit / 2;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (UART rx) do not look like an edge after
// reset.
module uart_sync #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic [1:0] chain_q;
   logic [1:0] chain_d;

   // Next value of each stage: stage 0 captures the pin, stage 1 follows it.
   always_comb begin
      chain_d = chain_q;
      chain_d[0] = async_i;
      chain_d[1] = chain_q[0];
   end

   // Synchronizer flops, both forced to the line idle level on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain_q <= {2{RESET_VALUE}};
      end else begin
         chain_q <= chain_d;
      end
   end

   assign sync_o = chain_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Decodes frames from the synchronized rx line using the
// same cycles_per_bit timing as the transmitter and presents each byte on a
// valid/ready output with one-cycle framing and overflow pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int cycles_per_bit = 434
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx,
   input  logic                      tready,
   output logic                      tvalid,
   output logic [UART_DATA_BITS-1:0] tdata,
   output logic                      framing_error,
   output logic                      overflow
);

   localparam int CW = $clog2(cycles_per_bit);
   // Start-bit midpoint: last count value before the start bit is sampled.
   localparam logic [CW-1:0] HALF_LAST  = CW'(half_bit_cycles(cycles_per_bit) - 1);
   // Last count value of a full bit period.
   localparam logic [CW-1:0] BIT_LAST   = CW'(cycles_per_bit - 1);
   localparam logic [CW-1:0] CYC_ONE    = CW'(1);
   localparam logic [2:0]    INDEX_LAST = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;

   rx_state_t                 state_q,  state_d;
   logic [CW-1:0]             cycles_q, cycles_d;
   logic [2:0]                index_q,  index_d;
   logic [UART_DATA_BITS-1:0] shreg_q,  shreg_d;
   logic                      tvalid_q, tvalid_d;
   logic [UART_DATA_BITS-1:0] tdata_q,  tdata_d;
   logic                      fe_q,     fe_d;
   logic                      ov_q,     ov_d;

   // The pin is asynchronous; everything below only looks at rx_s.
   uart_sync #(
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (rx),
      .sync_o  (rx_s)
   );

   // State, counters, shift register and output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cycles_q <= '0;
         index_q  <= '0;
         shreg_q  <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         fe_q     <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cycles_q <= cycles_d;
         index_q  <= index_d;
         shreg_q  <= shreg_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         fe_q     <= fe_d;
         ov_q     <= ov_d;
      end
   end

   // Frame decoding and output handshake.
   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      index_d  = index_q;
      shreg_d  = shreg_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      fe_d     = 1'b0;
      ov_d     = 1'b0;

      // Consumer took the byte; a load below in the same cycle overrides.
      if (tvalid_q && tready) begin
         tvalid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d  = ST_START;
               cycles_d = '0;
            end
         end

         ST_START: begin
            if (cycles_q == HALF_LAST) begin
               // Still low at mid-bit means a real start; high means a glitch.
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d  = ST_DATA;
                  cycles_d = '0;
                  index_d  = '0;
               end
            end else begin
               cycles_d = cycles_q + CYC_ONE;
            end
         end

         ST_DATA: begin
            if (cycles_q == BIT_LAST) begin
               // LSB arrives first, so shift in from the top.
               shreg_d  = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
               cycles_d = '0;
               if (index_q == INDEX_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  index_d = index_q + 3'd1;
               end
            end else begin
               cycles_d = cycles_q + CYC_ONE;
            end
         end

         ST_STOP: begin
            if (cycles_q == BIT_LAST) begin
               cycles_d = '0;
               if (rx_s) begin
                  // Re-arm immediately, half a bit early, so back-to-back
                  // frames are caught without a gap.
                  state_d = ST_IDLE;
                  if (!tvalid_q || tready) begin
                     tvalid_d = 1'b1;
                     tdata_d  = shreg_q;
                  end else begin
                     // Held byte wins; the new one is dropped.
                     ov_d = 1'b1;
                  end
               end else begin
                  fe_d    = 1'b1;
                  state_d = ST_RECOVER;
               end
            end else begin
               cycles_d = cycles_q + CYC_ONE;
            end
         end

         ST_RECOVER: begin
            // A held-low line (break) stays here, giving a single error pulse.
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tvalid        = tvalid_q;
   assign tdata         = tdata_q;
   assign framing_error = fe_q;
   assign overflow      = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with cycles_per_bit = 16. The bench drives
// the rx pin like a transmitter and keeps a frame-timing model that predicts
// the outputs from the sample-point formulas; a per-cycle compare checks the
// DUT against it, and directed literal checks pin the model.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int FULL = 10 * CPB;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       tready;
   logic       tvalid;
   logic [7:0] tdata;
   logic       framing_error;
   logic       overflow;

   uart_rx #(
      .cycles_per_bit (CPB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .tready        (tready),
      .tvalid        (tvalid),
      .tdata         (tdata),
      .framing_error (framing_error),
      .overflow      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit model_ready = 1'b0;

   // Model state: mode 0 = waiting for start, 1 = inside a frame, 2 = waiting
   // for the line to return high after a bad stop bit.
   int         m_mode = 0;
   int         k = 0;
   logic       d1 = 1'b1;
   logic       d2 = 1'b1;
   logic [7:0] m_byte = 8'h00;
   logic       exp_tvalid = 1'b0;
   logic [7:0] exp_tdata = 8'h00;
   logic       exp_fe = 1'b0;
   logic       exp_ov = 1'b0;

   // Bytes the DUT handed over (tvalid && tready at an edge).
   logic [7:0] got[$];

   // Observation counters kept by the compare process.
   int fe_cnt = 0;
   int ov_cnt = 0;
   int tv_cycles = 0;
   int rise_cyc = -1;

   // Snapshots taken at the start of each scenario.
   int base = 0;
   int fe0 = 0;
   int ov0 = 0;
   int tv0 = 0;
   int t_start = 0;

   // Per-edge model: rx_s is the pin two edges back; sample points are
   // taken at start-edge + HALF + n*CPB as measured from the first low seen.
   always @(posedge clk) begin : model_b
      logic s;
      logic deliver;
      int   n;
      cyc = cyc + 1;
      if (!rst_n) begin
         model_ready = 1'b1;
         m_mode      = 0;
         k           = 0;
         d1          = 1'b1;
         d2          = 1'b1;
         m_byte      = 8'h00;
         exp_tvalid  = 1'b0;
         exp_tdata   = 8'h00;
         exp_fe      = 1'b0;
         exp_ov      = 1'b0;
      end else begin
         if (tvalid === 1'b1 && tready === 1'b1) got.push_back(tdata);
         s       = d2;
         d2      = d1;
         d1      = rx;
         exp_fe  = 1'b0;
         exp_ov  = 1'b0;
         deliver = 1'b0;
         case (m_mode)
            0: if (!s) begin m_mode = 1; k = 0; end
            1: begin
               k = k + 1;
               if (k == HALF) begin
                  if (s) m_mode = 0;
               end else if (k > HALF && ((k - HALF) % CPB) == 0) begin
                  n = (k - HALF) / CPB - 1;
                  if (n < 8) begin
                     m_byte[n] = s;
                  end else if (s) begin
                     deliver = 1'b1;
                     m_mode  = 0;
                  end else begin
                     exp_fe = 1'b1;
                     m_mode = 2;
                  end
               end
            end
            default: if (s) m_mode = 0;
         endcase
         if (deliver) begin
            if (!exp_tvalid || tready) begin
               exp_tvalid = 1'b1;
               exp_tdata  = m_byte;
            end else begin
               exp_ov = 1'b1;
            end
         end else if (exp_tvalid && tready) begin
            exp_tvalid = 1'b0;
         end
      end
   end

   task automatic check_val(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic int got_at(input int i);
      if (i < got.size()) return int'(got[i]);
      return -1;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      base = got.size();
      fe0  = fe_cnt;
      ov0  = ov_cnt;
      tv0  = tv_cycles;
   endtask

   // Drives one 8N1 frame from a negedge, stopping after max_cycles cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int max_cycles);
      logic [9:0] f;
      int c;
      f = {stop_bit, b, 1'b0};
      c = 0;
      $display("frame 0x%02h stop=%0b cycles=%0d", b, stop_bit, max_cycles);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < CPB; j++) begin
            if (c >= max_cycles) return;
            rx = f[i];
            @(negedge clk);
            c = c + 1;
         end
      end
      rx = 1'b1;
   endtask

   initial begin
      rx     = 1'b1;
      tready = 1'b1;
      rst_n  = 1'b0;

      // Per-cycle comparison of DUT outputs against the model.
      fork
         begin : cmp_b
            logic prev_tv;
            prev_tv = 1'b0;
            forever begin
               @(negedge clk);
               if (model_ready) begin
                  checks = checks + 1;
                  if ({tvalid, tdata, framing_error, overflow} !==
                      {exp_tvalid, exp_tdata, exp_fe, exp_ov}) begin
                     errors = errors + 1;
                     $display("FAIL cycle %0d outputs tvalid/tdata/fe/ov actual=%b/%02h/%b/%b expected=%b/%02h/%b/%b",
                              cyc, tvalid, tdata, framing_error, overflow,
                              exp_tvalid, exp_tdata, exp_fe, exp_ov);
                  end
                  if (framing_error === 1'b1) fe_cnt = fe_cnt + 1;
                  if (overflow === 1'b1) ov_cnt = ov_cnt + 1;
                  if (tvalid === 1'b1) tv_cycles = tv_cycles + 1;
                  if (tvalid === 1'b1 && prev_tv == 1'b0) rise_cyc = cyc;
                  prev_tv = tvalid;
               end
            end
         end
      join_none

      idle(3);
      check_val("reset_outputs", int'({tvalid, tdata, framing_error, overflow}), 0);
      rst_n = 1'b1;
      idle(10);

      // 0x55 with tready high: one tvalid cycle. Pin changes half a cycle
      // before the edge that samples it, so start-to-tvalid is 8+144+2+1.
      snap();
      t_start = cyc;
      send_frame(8'h55, 1'b1, FULL);
      idle(20);
      check_val("t1_count", got.size() - base, 1);
      check_val("t1_byte", got_at(base), 'h55);
      check_val("t1_tvalid_cycles", tv_cycles - tv0, 1);
      check_val("t1_latency", rise_cyc - t_start, 155);

      // Back-to-back frames, no idle gap.
      snap();
      send_frame(8'h00, 1'b1, FULL);
      send_frame(8'hFF, 1'b1, FULL);
      send_frame(8'hA5, 1'b1, FULL);
      idle(20);
      check_val("t2_count", got.size() - base, 3);
      check_val("t2_byte0", got_at(base), 'h00);
      check_val("t2_byte1", got_at(base + 1), 'hFF);
      check_val("t2_byte2", got_at(base + 2), 'hA5);
      check_val("t2_fe", fe_cnt - fe0, 0);
      check_val("t2_ov", ov_cnt - ov0, 0);

      // Short low glitch is rejected, then a real frame follows.
      snap();
      $display("glitch low 5 cycles");
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      check_val("t3_glitch_count", got.size() - base, 0);
      check_val("t3_glitch_tvalid", tv_cycles - tv0, 0);
      check_val("t3_glitch_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      send_frame(8'h3C, 1'b1, FULL);
      idle(20);
      check_val("t3_count", got.size() - base, 1);
      check_val("t3_byte", got_at(base), 'h3C);

      // Bad stop bit followed by a break, then recovery.
      snap();
      send_frame(8'hA5, 1'b0, FULL);
      rx = 1'b0;
      idle(3 * CPB);
      rx = 1'b1;
      idle(2 * CPB);
      check_val("t4_fe", fe_cnt - fe0, 1);
      check_val("t4_no_byte", got.size() - base, 0);
      send_frame(8'h3C, 1'b1, FULL);
      idle(20);
      check_val("t4_count", got.size() - base, 1);
      check_val("t4_byte", got_at(base), 'h3C);

      // Backpressure: second byte overflows, first is held.
      snap();
      tready = 1'b0;
      send_frame(8'h11, 1'b1, FULL);
      send_frame(8'h22, 1'b1, FULL);
      idle(20);
      check_val("t5_ov", ov_cnt - ov0, 1);
      check_val("t5_tdata_held", int'(tdata), 'h11);
      check_val("t5_tvalid_held", int'(tvalid), 1);
      tready = 1'b1;
      idle(3);
      check_val("t5_count", got.size() - base, 1);
      check_val("t5_byte", got_at(base), 'h11);
      check_val("t5_tvalid_fall", int'(tvalid), 0);

      // Reset during data bit 3 of 0x77 aborts the frame.
      snap();
      send_frame(8'h77, 1'b1, 4 * CPB + HALF);
      rx    = 1'b1;
      rst_n = 1'b0;
      idle(2);
      check_val("t6_reset_tdata", int'(tdata), 0);
      check_val("t6_reset_flags", int'({tvalid, framing_error, overflow}), 0);
      rst_n = 1'b1;
      idle(40);
      check_val("t6_no_byte", got.size() - base, 0);
      check_val("t6_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      send_frame(8'h81, 1'b1, FULL);
      idle(20);
      check_val("t6_count", got.size() - base, 1);
      check_val("t6_byte", got_at(base), 'h81);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
